// File: rtl/sd_dma_pkg.sv
// Shared types and defaults for the SD-to-DMA write path.
package sd_dma_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT} wr_state_e;

  localparam int BEAT_BYTES      = 8;
  localparam int DEF_BURST_BEATS = 64;
  localparam int DEF_FIFO_DEPTH  = 128;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on dout while not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gate the head with empty so the output is clean zero after reset.
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/sd_dma_wpacker.sv
// Packs SD bytes little-endian into 64-bit words and drains them to DDR as DMA write bursts.
module sd_dma_wpacker
  import sd_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          BURST_BEATS = DEF_BURST_BEATS,
  parameter int          FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clk_50M,
  input  logic        dma_rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] dma_waddr,
  output logic        dma_wareq,
  output logic [15:0] dma_wsize,
  input  logic        dma_wbusy,
  output logic [63:0] dma_wdata,
  input  logic        dma_wvalid,
  output logic        dma_wready,
  output logic        done
);
  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_BEATS);

  logic             run_reg, flushing_reg;
  logic [2:0]       byte_idx_reg;
  logic [63:0]      shift_reg;
  logic             pend_valid_reg;
  logic [63:0]      pend_word_reg;
  wr_state_e        state_reg;
  logic [15:0]      beats_left_reg;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [63:0]      fifo_din;
  logic [CNT_W-1:0] fifo_count;
  logic             in_fire, word_done;
  logic [63:0]      word_next;
  logic [15:0]      burst_size;

  // A completed word that meets a full FIFO parks in pend_word_reg; input stalls only then.
  assign in_ready  = run_reg && !flushing_reg && !pend_valid_reg;
  assign in_fire   = in_valid && in_ready;
  assign word_done = in_fire && (in_last || byte_idx_reg == 3'(BEAT_BYTES-1));

  for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
    assign word_next[gi*8 +: 8] = (byte_idx_reg == 3'(gi)) ? in_data : shift_reg[gi*8 +: 8];
  end

  assign fifo_push  = pend_valid_reg ? !fifo_full : word_done && !fifo_full;
  assign fifo_din   = pend_valid_reg ? pend_word_reg : word_next;
  assign dma_wready = (state_reg == DATA) && !fifo_empty && (beats_left_reg != 16'd0);
  assign fifo_pop   = dma_wready && dma_wvalid;
  assign burst_size = (fifo_count >= BURST_CNT) ? 16'(BURST_BEATS) : 16'(fifo_count);

  sync_fifo_fwft #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50M),
    .rst_n (dma_rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (dma_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_50M or negedge dma_rst_n) begin
    if (!dma_rst_n) begin
      run_reg        <= 1'b0;
      flushing_reg   <= 1'b0;
      byte_idx_reg   <= '0;
      shift_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_word_reg  <= '0;
    end else begin
      run_reg <= 1'b1;
      if (in_fire) begin
        if (word_done) begin
          shift_reg    <= '0;
          byte_idx_reg <= '0;
        end else begin
          shift_reg    <= word_next;
          byte_idx_reg <= byte_idx_reg + 1'b1;
        end
        if (in_last) flushing_reg <= 1'b1;
      end
      if (pend_valid_reg) begin
        if (!fifo_full) pend_valid_reg <= 1'b0;
      end else if (word_done && fifo_full) begin
        pend_valid_reg <= 1'b1;
        pend_word_reg  <= word_next;
      end
      if (start && state_reg == IDLE) flushing_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge dma_rst_n) begin
    if (!dma_rst_n) begin
      state_reg      <= IDLE;
      dma_wareq      <= 1'b0;
      dma_wsize      <= '0;
      beats_left_reg <= '0;
      dma_waddr      <= BASE_ADDR;
      done           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dma_waddr <= BASE_ADDR;
            done      <= 1'b0;
          end else if (fifo_count >= BURST_CNT || (flushing_reg && fifo_count != '0)) begin
            dma_wsize      <= burst_size;
            beats_left_reg <= burst_size;
            dma_wareq      <= 1'b1;
            state_reg      <= REQ;
          end
        end
        REQ: begin
          if (dma_wbusy) begin
            dma_wareq <= 1'b0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (fifo_pop) begin
            beats_left_reg <= beats_left_reg - 1'b1;
            if (beats_left_reg == 16'd1) state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (!dma_wbusy) begin
            dma_waddr <= dma_waddr + (32'(dma_wsize) << 3);
            if (flushing_reg && fifo_empty && !pend_valid_reg && byte_idx_reg == 3'd0)
              done <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
